// File: rtl/out_fm_store_tile_sched.sv
// ---------------------------------------------------------------------------
// out_fm_store_tile_sched
//
// Schedules the store of every output feature-map tile of one layer. The
// compute side announces each finished tile with a tile_ready pulse, which is
// banked as a pending credit. Each credit lets the scheduler issue one
// store_start to the store datapath with the tile's base coordinates. It then
// waits for store_done and moves on to the next tile. Tile order is channel
// fastest, then column, then row.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   sched_start    pulse: begin a full-layer store sequence (only seen in IDLE)
//   tile_ready     pulse: one more output tile is queued for storing
//   store_start    pulse: start storing the tile at tile_base_*
//   store_done     current tile store finished (first cycle seen in WAIT_DONE)
//   tile_base_n    channel base of the current tile
//   tile_base_row  row base of the current tile
//   tile_base_col  column base of the current tile
//   sched_busy     high while a sequence is in progress
//   sched_done     pulse after the last tile has stored
//   tile_cnt       tiles stored in the current or most recent sequence
//   sched_err      sticky: a tile_ready arrived with the credit counter full
// ---------------------------------------------------------------------------
module out_fm_store_tile_sched #(
    parameter int CW       = 16,
    parameter int M        = 32,
    parameter int R        = 64,
    parameter int C        = 32,
    parameter int Tm       = 16,
    parameter int Tr       = 64,
    parameter int Tc       = 16,
    parameter int PEND_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sched_start,
    input  logic          tile_ready,
    output logic          store_start,
    input  logic          store_done,
    output logic [CW-1:0] tile_base_n,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic          sched_busy,
    output logic          sched_done,
    output logic [CW-1:0] tile_cnt,
    output logic          sched_err
);

    localparam int PW = $clog2(PEND_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   pend_reg;
    logic            store_start_reg;
    logic            sched_busy_reg;
    logic            sched_done_reg;
    logic            sched_err_reg;
    logic [CW-1:0]   tile_cnt_reg;

    // Tile base registers, index 0 = channel, 1 = column, 2 = row. The index
    // order is also the stepping order: channel steps fastest.
    logic [CW-1:0]   base_reg  [3];
    logic [CW-1:0]   base_next [3];
    logic [CW:0]     base_sum  [3];
    logic [2:0]      wrap;
    logic [3:0]      carry;
    logic            last_tile;

    logic            credit_inc;
    logic            credit_dec;

    // Ripple-carry tile walker: a dimension advances only when every faster
    // dimension wraps. The sum is one bit wider so base+step never overflows
    // before being compared with the dimension.
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dim
            localparam int STEP = (gi == 0) ? Tm : ((gi == 1) ? Tc : Tr);
            localparam int DIM  = (gi == 0) ? M  : ((gi == 1) ? C  : R);

            assign base_sum[gi]  = {1'b0, base_reg[gi]} + (CW+1)'(STEP);
            assign wrap[gi]      = (base_sum[gi] >= (CW+1)'(DIM));
            assign carry[gi+1]   = carry[gi] & wrap[gi];
            assign base_next[gi] = !carry[gi] ? base_reg[gi]
                                 : (wrap[gi] ? '0 : base_sum[gi][CW-1:0]);
        end
    endgenerate

    // Every dimension wrapping at once means this is the final tile.
    assign last_tile = carry[3];

    // Credits arrive any time a sequence is live and are consumed on the
    // WAIT_RDY -> ISSUE transition.
    assign credit_inc = tile_ready && (state_reg != IDLE);
    assign credit_dec = (state_reg == WAIT_RDY) && (pend_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            pend_reg        <= '0;
            store_start_reg <= 1'b0;
            sched_busy_reg  <= 1'b0;
            sched_done_reg  <= 1'b0;
            sched_err_reg   <= 1'b0;
            tile_cnt_reg    <= '0;
            for (int i = 0; i < 3; i++) begin
                base_reg[i] <= '0;
            end
        end else begin
            store_start_reg <= 1'b0;
            sched_done_reg  <= 1'b0;

            // Credit bookkeeping. A simultaneous arrival and consume cancel.
            if (state_reg == IDLE) begin
                if (sched_start) begin
                    pend_reg      <= '0;
                    sched_err_reg <= 1'b0;
                end
            end else if (credit_inc && !credit_dec) begin
                if (pend_reg == PW'(PEND_MAX)) begin
                    sched_err_reg <= 1'b1;
                end else begin
                    pend_reg <= pend_reg + PW'(1);
                end
            end else if (credit_dec && !credit_inc) begin
                pend_reg <= pend_reg - PW'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (sched_start) begin
                        state_reg      <= WAIT_RDY;
                        sched_busy_reg <= 1'b1;
                        tile_cnt_reg   <= '0;
                        for (int i = 0; i < 3; i++) begin
                            base_reg[i] <= '0;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (pend_reg != '0) begin
                        state_reg       <= ISSUE;
                        store_start_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Bases only move after store_done, so they stay stable
                    // for the whole store of the current tile.
                    if (store_done) begin
                        tile_cnt_reg <= tile_cnt_reg + CW'(1);
                        if (last_tile) begin
                            state_reg      <= FINISH;
                            sched_done_reg <= 1'b1;
                            sched_busy_reg <= 1'b0;
                            for (int i = 0; i < 3; i++) begin
                                base_reg[i] <= '0;
                            end
                        end else begin
                            state_reg <= WAIT_RDY;
                            for (int i = 0; i < 3; i++) begin
                                base_reg[i] <= base_next[i];
                            end
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign store_start   = store_start_reg;
    assign sched_busy    = sched_busy_reg;
    assign sched_done    = sched_done_reg;
    assign sched_err     = sched_err_reg;
    assign tile_cnt      = tile_cnt_reg;
    assign tile_base_n   = base_reg[0];
    assign tile_base_col = base_reg[1];
    assign tile_base_row = base_reg[2];

endmodule

// File: tb/tb_out_fm_store_tile_sched.sv
// ---------------------------------------------------------------------------
// Testbench for out_fm_store_tile_sched with default parameters
// (M=32, R=64, C=32, Tm=16, Tr=64, Tc=16 -> 4 tiles per layer).
// Expected store_start bases and sched_done tile counts are pushed into a
// queue by the stimulus; a negedge monitor pops and compares them whenever
// the DUT pulses store_start or sched_done.
// ---------------------------------------------------------------------------
module tb_out_fm_store_tile_sched;

    logic        clk;
    logic        rst;
    logic        sched_start;
    logic        tile_ready;
    logic        store_start;
    logic        store_done;
    logic [15:0] tile_base_n;
    logic [15:0] tile_base_row;
    logic [15:0] tile_base_col;
    logic        sched_busy;
    logic        sched_done;
    logic [15:0] tile_cnt;
    logic        sched_err;

    out_fm_store_tile_sched dut (
        .clk           (clk),
        .rst           (rst),
        .sched_start   (sched_start),
        .tile_ready    (tile_ready),
        .store_start   (store_start),
        .store_done    (store_done),
        .tile_base_n   (tile_base_n),
        .tile_base_row (tile_base_row),
        .tile_base_col (tile_base_col),
        .sched_busy    (sched_busy),
        .sched_done    (sched_done),
        .tile_cnt      (tile_cnt),
        .sched_err     (sched_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [15:0] n;
        logic [15:0] row;
        logic [15:0] col;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;

    int vectors     = 0;
    int miscompares = 0;

    // Hand-computed tile order for the default geometry: (n,row,col).
    logic [15:0] tbl_n   [4] = '{16'd0, 16'd16, 16'd0,  16'd16};
    logic [15:0] tbl_row [4] = '{16'd0, 16'd0,  16'd0,  16'd0};
    logic [15:0] tbl_col [4] = '{16'd0, 16'd0,  16'd16, 16'd16};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the first nstores tiles of a sequence; a full sequence also
    // queues the sched_done event with the final tile count.
    task automatic push_seq(input int nstores);
        exp_t e;
        for (int i = 0; i < nstores; i++) begin
            e.is_done = 1'b0;
            e.n = tbl_n[i];
            e.row = tbl_row[i];
            e.col = tbl_col[i];
            e.cnt = 16'd0;
            exp_q.push_back(e);
        end
        if (nstores == 4) begin
            e.is_done = 1'b1;
            e.n = 16'd0;
            e.row = 16'd0;
            e.col = 16'd0;
            e.cnt = 16'd4;
            exp_q.push_back(e);
        end
    endtask

    // Count cycles after the stimulus cycle until store_start shows up.
    task automatic wait_store(input string name, input int exp_k);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!store_start && k < 20);
        check({name, " store_start latency"}, k, exp_k);
    endtask

    // Must be called while the DUT is in WAIT_DONE.
    task automatic do_store_done(input bit with_ready, input bit with_start);
        check("base_n stable", tile_base_n, cur_exp.n);
        check("base_row stable", tile_base_row, cur_exp.row);
        check("base_col stable", tile_base_col, cur_exp.col);
        store_done  = 1'b1;
        tile_ready  = with_ready;
        sched_start = with_start;
        tick();
        store_done  = 1'b0;
        tile_ready  = 1'b0;
        sched_start = 1'b0;
    endtask

    task automatic pulse_start();
        sched_start = 1'b1;
        tick();
        sched_start = 1'b0;
    endtask

    task automatic check_finish(input string name);
        check({name, " sched_done"}, sched_done, 1);
        check({name, " busy low"}, sched_busy, 0);
        check({name, " tile_cnt"}, tile_cnt, 4);
        check({name, " base_n zero"}, tile_base_n, 0);
        check({name, " base_col zero"}, tile_base_col, 0);
        tick();
        check({name, " sched_done one cycle"}, sched_done, 0);
        check({name, " tile_cnt held"}, tile_cnt, 4);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (store_start) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    check("unexpected store_start", 1, 0);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    cur_exp = exp_q.pop_front();
                    $display("store_start n=%0d row=%0d col=%0d", tile_base_n, tile_base_row, tile_base_col);
                    check("store base_n", tile_base_n, cur_exp.n);
                    check("store base_row", tile_base_row, cur_exp.row);
                    check("store base_col", tile_base_col, cur_exp.col);
                end
            end
            if (sched_done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    check("unexpected sched_done", 1, 0);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    exp_t d;
                    d = exp_q.pop_front();
                    $display("sched_done tile_cnt=%0d", tile_cnt);
                    check("done tile_cnt", tile_cnt, d.cnt);
                    check("done busy", sched_busy, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst = 1'b1;
        sched_start = 1'b0;
        tile_ready = 1'b0;
        store_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check("rst store_start", store_start, 0);
        check("rst busy", sched_busy, 0);
        check("rst done", sched_done, 0);
        check("rst err", sched_err, 0);
        check("rst tile_cnt", tile_cnt, 0);
        check("rst bases", {tile_base_n, tile_base_row}, 0);
        check("rst base_col", tile_base_col, 0);

        // Basic sequence, one credit per tile, credit given with store_done.
        push_seq(4);
        pulse_start();
        check("seq1 busy", sched_busy, 1);
        tile_ready = 1'b1;
        tick();
        tile_ready = 1'b0;
        wait_store("seq1 t1", 1);
        tick();
        for (int t = 1; t < 4; t++) begin
            do_store_done(1'b1, 1'b0);
            check("seq1 tile_cnt", tile_cnt, t);
            wait_store("seq1 next", 1);
            tick();
        end
        do_store_done(1'b0, 1'b0);
        check_finish("seq1");

        // Four credits banked up front: no stall between tiles.
        push_seq(4);
        pulse_start();
        tile_ready = 1'b1;
        repeat (4) tick();
        tile_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            do_store_done(1'b0, 1'b0);
            wait_store("banked", 1);
            tick();
        end
        do_store_done(1'b0, 1'b0);
        check_finish("banked");

        // Starvation: WAIT_RDY holds with no credit, resumes on a pulse.
        push_seq(4);
        pulse_start();
        tile_ready = 1'b1;
        tick();
        tile_ready = 1'b0;
        wait_store("starve t1", 1);
        tick();
        do_store_done(1'b0, 1'b0);
        seen = 0;
        repeat (12) begin
            tick();
            if (store_start) seen++;
        end
        check("starve no store_start", seen, 0);
        check("starve busy", sched_busy, 1);
        tile_ready = 1'b1;
        tick();
        tile_ready = 1'b0;
        wait_store("starve resume", 1);
        tick();
        tile_ready = 1'b1;
        do_store_done(1'b1, 1'b0);
        wait_store("starve t3", 1);
        tick();
        do_store_done(1'b1, 1'b0);
        wait_store("starve t4", 1);
        tick();
        do_store_done(1'b0, 1'b0);
        check_finish("starve");

        // Credit overflow: 9 pulses fill to PEND_MAX, the 10th overflows.
        push_seq(4);
        pulse_start();
        tile_ready = 1'b1;
        repeat (9) tick();
        check("ovf err at full", sched_err, 0);
        tick();
        tile_ready = 1'b0;
        check("ovf err set", sched_err, 1);
        for (int t = 0; t < 3; t++) begin
            do_store_done(1'b0, 1'b0);
            wait_store("ovf drain", 1);
            check("ovf err sticky", sched_err, 1);
            tick();
        end
        do_store_done(1'b0, 1'b0);
        check("ovf err at finish", sched_err, 1);
        check_finish("ovf");
        check("ovf err in idle", sched_err, 1);

        // Reset in WAIT_DONE of tile 2.
        push_seq(2);
        pulse_start();
        check("rstmid err cleared", sched_err, 0);
        check("rstmid tile_cnt cleared", tile_cnt, 0);
        tile_ready = 1'b1;
        tick();
        tile_ready = 1'b0;
        wait_store("rstmid t1", 1);
        tick();
        do_store_done(1'b1, 1'b0);
        wait_store("rstmid t2", 1);
        tick();
        rst = 1'b1;
        tick();
        check("rstmid busy", sched_busy, 0);
        check("rstmid tile_cnt", tile_cnt, 0);
        check("rstmid base_n", tile_base_n, 0);
        check("rstmid store_start", store_start, 0);
        rst = 1'b0;
        store_done = 1'b1;
        tile_ready = 1'b1;
        seen = 0;
        repeat (3) begin
            tick();
            if (store_start || sched_busy || sched_done || tile_cnt != 0) seen++;
        end
        store_done = 1'b0;
        tile_ready = 1'b0;
        check("rstmid late store_done ignored", seen, 0);

        // Restart; credits from the IDLE tile_ready pulses must not count.
        push_seq(4);
        pulse_start();
        seen = 0;
        repeat (5) begin
            tick();
            if (store_start) seen++;
        end
        check("idle tile_ready ignored", seen, 0);

        // tile_ready and sched_start coincide with ISSUE entry.
        tile_ready = 1'b1;
        tick();
        sched_start = 1'b1;
        tick();
        tile_ready = 1'b0;
        sched_start = 1'b0;
        check("coincide store_start", store_start, 1);
        tick();
        do_store_done(1'b0, 1'b0);
        wait_store("retained credit", 1);
        tick();
        do_store_done(1'b1, 1'b1);
        wait_store("busy start t3", 1);
        tick();
        do_store_done(1'b1, 1'b0);
        wait_store("busy start t4", 1);
        tick();
        do_store_done(1'b0, 1'b0);
        check_finish("restart");

        check("queue drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
